// File: rtl/mem_stage_ctrl.sv
// Data-memory access sequencer for the EXE->MEM stage: req/ack handshake, pipeline freeze, load capture.
// Optional ack watchdog with sticky err when MEM_TIMEOUT_EN is defined.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_En,
  input  logic              MEM_W_En,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              freeze,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  if (2**CNT_W <= TIMEOUT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT");
  end

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              req_in;
  logic [1:0]        unused_addr_lsb;

  assign req_in          = MEM_R_En | MEM_W_En;
  assign unused_addr_lsb = ALU_result[1:0];

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_in) begin
          state_d     = ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = MEM_W_En;  // simultaneous R/W resolves to a store
          mem_addr_d  = {ALU_result[DATA_W-1:2], 2'b00};
          mem_wdata_d = st_data;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          load_valid_d = 1'b1;
          if (!mem_we_q) begin
            load_data_d = mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // this cycle is the TIMEOUT-th without ack; ack above takes priority
        else if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          load_valid_d = 1'b1;
          load_data_d  = '1;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // rst gates freeze so a pending request cannot hold the pipeline during reset
  assign freeze     = ~rst & (((state_q == IDLE) & req_in) | (state_q == ACCESS));
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, hand sequences and random traffic vs a transaction model.
module tb_mem_stage_ctrl;

  localparam int TO = 8;

  logic        clk, rst;
  logic        MEM_R_En, MEM_W_En, mem_ack;
  logic [31:0] ALU_result, st_data, mem_rdata;
  logic        mem_req, mem_we, freeze, load_valid, err;
  logic [31:0] mem_addr, mem_wdata, load_data;

  mem_stage_ctrl #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_En(MEM_R_En), .MEM_W_En(MEM_W_En),
    .ALU_result(ALU_result), .st_data(st_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .freeze(freeze), .load_data(load_data), .load_valid(load_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level reference: one outstanding access, then a single completion cycle
  bit          m_busy, m_done, m_req, m_we, m_lv, m_err;
  logic [31:0] m_addr, m_wdata, m_ld;
  int          m_wait;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_req = 0; m_we = 0; m_lv = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_ld = 0; m_wait = 0;
  endtask

  task automatic finish_access(input logic [31:0] ld_val, input bit upd_ld, input bit to_err);
    m_busy = 0; m_done = 1; m_req = 0; m_lv = 1;
    if (upd_ld) m_ld = ld_val;
    if (to_err) m_err = 1;
  endtask

  task automatic model_edge(input bit r, input bit w, input logic [31:0] alu, input logic [31:0] st,
                            input bit ack, input logic [31:0] rd);
    if (m_done) begin
      m_done = 0; m_lv = 0;
    end else if (m_busy) begin
      if (ack) finish_access(rd, !m_we, 0);
`ifdef MEM_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TO) finish_access(32'hFFFF_FFFF, 1, 1);
      end
`endif
    end else if (r || w) begin
      m_busy = 1; m_req = 1; m_we = w;
      m_addr = (alu / 4) * 4;
      m_wdata = st; m_wait = 0;
    end
  endtask

  int frz_cnt;
  int cyc;
  int lv_cyc[$];
  int req_cyc[$];
  logic prev_req;

  // drive at negedge, check freeze mid-cycle, check registered outputs just after posedge
  task automatic step(input bit r, input bit w, input logic [31:0] alu, input logic [31:0] st,
                      input bit ack, input logic [31:0] rd);
    MEM_R_En = r; MEM_W_En = w; ALU_result = alu; st_data = st; mem_ack = ack; mem_rdata = rd;
    #1;
    chk("freeze", {31'd0, freeze}, {31'd0, (m_busy || (!m_done && (r || w)))});
    if (freeze) frz_cnt++;
    @(posedge clk);
    model_edge(r, w, alu, st, ack, rd);
    #1;
    cyc++;
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
    chk("load_valid", {31'd0, load_valid}, {31'd0, m_lv});
    chk("load_data", load_data, m_ld);
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (m_req) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (load_valid) lv_cyc.push_back(cyc);
    if (mem_req && !prev_req) req_cyc.push_back(cyc);
    prev_req = mem_req;
    @(negedge clk);
  endtask

  task automatic do_reset();
    MEM_R_En = 0; MEM_W_En = 0; ALU_result = 0; st_data = 0; mem_ack = 0; mem_rdata = 0;
    rst = 1;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_lv", {31'd0, load_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_frz", {31'd0, freeze}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    frz_cnt = 0; cyc = 0; prev_req = 0;
    lv_cyc.delete(); req_cyc.delete();
  endtask

  typedef struct {
    logic r, w; logic [31:0] alu, st; logic ack; logic [31:0] rd;
    logic e_frz, e_req, e_we; logic [31:0] e_addr, e_wdata; logic e_lv; logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          r  w  alu          st           ack rd            frz req we addr         wdata        lv ld
    tbl[0]  = '{1, 0, 32'h104,     32'h0,       0, 32'h0,         1, 1, 0, 32'h104,     32'h0,       0, 32'h0};
    tbl[1]  = '{1, 0, 32'h104,     32'h0,       1, 32'hCAFEF00D,  1, 0, 0, 32'h0,       32'h0,       1, 32'hCAFEF00D};
    tbl[2]  = '{1, 0, 32'h104,     32'h0,       0, 32'h0,         0, 0, 0, 32'h0,       32'h0,       0, 32'hCAFEF00D};
    tbl[3]  = '{0, 0, 32'h0,       32'h0,       1, 32'hDEADBEEF,  0, 0, 0, 32'h0,       32'h0,       0, 32'hCAFEF00D};
    tbl[4]  = '{1, 1, 32'h3FF,     32'hA5A5A5A5, 0, 32'h0,        1, 1, 1, 32'h3FC,     32'hA5A5A5A5, 0, 32'hCAFEF00D};
    tbl[5]  = '{1, 1, 32'h3FF,     32'hA5A5A5A5, 0, 32'h0,        1, 1, 1, 32'h3FC,     32'hA5A5A5A5, 0, 32'hCAFEF00D};
    tbl[6]  = '{1, 1, 32'h3FF,     32'hA5A5A5A5, 1, 32'h11111111, 1, 0, 0, 32'h0,       32'h0,       1, 32'hCAFEF00D};
    tbl[7]  = '{0, 0, 32'h0,       32'h0,       0, 32'h0,         0, 0, 0, 32'h0,       32'h0,       0, 32'hCAFEF00D};
    tbl[8]  = '{0, 1, 32'h8,       32'h55,      1, 32'h0,         1, 1, 1, 32'h8,       32'h55,      0, 32'hCAFEF00D};
    tbl[9]  = '{0, 1, 32'h8,       32'h55,      1, 32'h22222222,  1, 0, 0, 32'h0,       32'h0,       1, 32'hCAFEF00D};
    tbl[10] = '{0, 0, 32'h0,       32'h0,       0, 32'h0,         0, 0, 0, 32'h0,       32'h0,       0, 32'hCAFEF00D};

    rst = 1; MEM_R_En = 0; MEM_W_En = 0; ALU_result = 0; st_data = 0; mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      MEM_R_En = tbl[i].r; MEM_W_En = tbl[i].w; ALU_result = tbl[i].alu; st_data = tbl[i].st;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("vec%0d_frz", i), {31'd0, freeze}, {31'd0, tbl[i].e_frz});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_lv", i), {31'd0, load_valid}, {31'd0, tbl[i].e_lv});
      chk($sformatf("vec%0d_ld", i), load_data, tbl[i].e_ld);
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_we", i), {31'd0, mem_we}, {31'd0, tbl[i].e_we});
        chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      @(negedge clk);
    end

    // store with ack in the 4th ACCESS cycle; changing st_data must not disturb mem_wdata
    do_reset();
    step(0, 1, 32'h203, 32'h12345678, 0, 0);
    step(0, 1, 32'h203, 32'h0BADBEEF, 0, 0);
    step(0, 1, 32'h207, 32'h0BADBEEF, 0, 0);
    step(0, 1, 32'h203, 32'h12345678, 0, 32'h77777777);
    step(0, 1, 32'h203, 32'h12345678, 1, 32'h99999999);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    chk("store_frz_cycles", frz_cnt, 5);
    chk("store_ld_unchanged", load_data, 32'h0);

    // back-to-back loads, ack with 0 and 0 waits
    do_reset();
    step(1, 0, 32'h40, 0, 0, 0);
    step(1, 0, 32'h40, 0, 1, 32'h1);
    step(1, 0, 32'h40, 0, 0, 0);
    step(1, 0, 32'h44, 0, 0, 0);
    step(1, 0, 32'h44, 0, 1, 32'h2);
    step(0, 0, 0, 0, 0, 0);
    chk("b2b_lv_count", lv_cyc.size(), 2);
    if (lv_cyc.size() == 2) chk("b2b_lv_gap", lv_cyc[1] - lv_cyc[0], 3);
    chk("b2b_req_count", req_cyc.size(), 2);
    if (req_cyc.size() == 2 && lv_cyc.size() == 2) chk("b2b_req_after_done", req_cyc[1] - lv_cyc[0], 2);

    // back-to-back loads, ack with 0 and 2 waits
    do_reset();
    step(1, 0, 32'h50, 0, 0, 0);
    step(1, 0, 32'h50, 0, 1, 32'h3);
    step(1, 0, 32'h50, 0, 0, 0);
    step(1, 0, 32'h58, 0, 0, 0);
    step(1, 0, 32'h58, 0, 0, 0);
    step(1, 0, 32'h58, 0, 0, 0);
    step(1, 0, 32'h58, 0, 1, 32'h4);
    step(0, 0, 0, 0, 0, 0);
    chk("b2b_w2_lv_count", lv_cyc.size(), 2);
    if (lv_cyc.size() == 2) chk("b2b_w2_lv_gap", lv_cyc[1] - lv_cyc[0], 5);

    // reset mid-ACCESS with the request still presented
    do_reset();
    step(1, 0, 32'h80, 0, 0, 0);
    #2;
    rst = 1;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_frz", {31'd0, freeze}, 32'd0);
    chk("midrst_lv", {31'd0, load_valid}, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset(); prev_req = 0;
    step(1, 0, 32'h84, 0, 0, 0);
    step(1, 0, 32'h84, 0, 1, 32'h600D600D);
    chk("midrst_lv_pulse", {31'd0, load_valid}, 32'd1);
    #2;
    rst = 1;
    #1;
    chk("donerst_lv", {31'd0, load_valid}, 32'd0);
    chk("donerst_ld", load_data, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset(); prev_req = 0;

`ifdef MEM_TIMEOUT_EN
    do_reset();
    step(1, 0, 32'h100, 0, 0, 0);
    for (int i = 0; i < TO; i++) step(1, 0, 32'h100, 0, 0, 0);
    chk("to_frz_cycles", frz_cnt, TO + 1);
    chk("to_ld", load_data, 32'hFFFF_FFFF);
    chk("to_err", {31'd0, err}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h104, 0, 0, 0);
    step(1, 0, 32'h104, 0, 1, 32'h5);
    step(0, 0, 0, 0, 0, 0);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    step(1, 0, 32'h108, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(1, 0, 32'h108, 0, 0, 0);
    step(1, 0, 32'h108, 0, 1, 32'h5);
    chk("to_ack_wins_err", {31'd0, err}, 32'd0);
    chk("to_ack_wins_ld", load_data, 32'h5);
    step(0, 0, 0, 0, 0, 0);
`else
    do_reset();
    step(1, 0, 32'h100, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 32'h100, 0, 0, 0);
    chk("noto_frz_cycles", frz_cnt, 301);
    chk("noto_err", {31'd0, err}, 32'd0);
    step(1, 0, 32'h100, 0, 1, 32'h5);
    chk("noto_late_ld", load_data, 32'h5);
    step(0, 0, 0, 0, 0, 0);
`endif

    // random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, w, a;
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 2) == 0);
      step(r, w, $urandom, $urandom, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
